// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle control FSM for the RV32I core. Sequences fetch,
//                decode, execute, memory and writeback over the shared ALU,
//                register file and single memory port. Every datapath enable
//                and mux select is decoded from the registered state plus the
//                current instruction fields, ALU flags and memory handshake.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_STATE_FETCH : 1 = first fetch on the first clk edge after rst falls
//                        0 = one IDLE cycle precedes the first fetch
//  Build option
//    CTRL_ILLEGAL_TRAP_EN : when defined, an undecodable opcode or branch
//                           funct3 sets the sticky illegal flag and halts.
//                           When undefined, it retires as a NOP.
//  Ports
//    clk, rst             : clock (rising edge), async active-high reset
//    opcode/funct3/funct7_5 : instruction fields from the decoder
//    alu_zero/lt/ltu      : ALU comparison flags for branches
//    mem_ready            : memory completes the current request
//    ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_src,
//    alu_src_a, alu_src_b, alu_op, rf_write, wb_src : datapath controls
//    halted, illegal, state : status / debug
//  State encoding (state output)
//    0 IDLE  1 FETCH  2 DECODE  3 EXEC_R  4 EXEC_I  5 LUI  6 AUIPC
//    7 ALU_WB  8 ADDR  9 MEM_RD  10 MEM_WB  11 MEM_WR  12 BRANCH
//    13 JAL  14 JALR  15 HALT
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int RESET_STATE_FETCH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       rf_write,
    output logic [1:0] wb_src,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_LUI    = 4'd5,
        S_AUIPC  = 4'd6,
        S_ALU_WB = 4'd7,
        S_ADDR   = 4'd8,
        S_MEM_RD = 4'd9,
        S_MEM_WB = 4'd10,
        S_MEM_WR = 4'd11,
        S_BRANCH = 4'd12,
        S_JAL    = 4'd13,
        S_JALR   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    localparam state_t c_RESET_STATE = (RESET_STATE_FETCH != 0) ? S_FETCH : S_IDLE;

    // Opcodes
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // ALU operations
    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    // Mux selects
    localparam logic [1:0] c_PC_ALU      = 2'd0;
    localparam logic [1:0] c_PC_ALUOUT   = 2'd1;
    localparam logic [1:0] c_PC_ALU_EVEN = 2'd2;
    localparam logic [1:0] c_A_PC        = 2'd0;
    localparam logic [1:0] c_A_OLD_PC    = 2'd1;
    localparam logic [1:0] c_A_RS1       = 2'd2;
    localparam logic [1:0] c_A_ZERO      = 2'd3;
    localparam logic [1:0] c_B_RS2       = 2'd0;
    localparam logic [1:0] c_B_IMM       = 2'd1;
    localparam logic [1:0] c_B_FOUR      = 2'd2;
    localparam logic [1:0] c_WB_ALUOUT   = 2'd0;
    localparam logic [1:0] c_WB_MDR      = 2'd1;
    localparam logic [1:0] c_WB_PC       = 2'd2;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_bad_instr;
    logic       w_branch_taken;
    logic [3:0] w_exec_op;

    logic       w_ir_write;
    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_addr_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [3:0] w_alu_op;
    logic       w_rf_write;
    logic [1:0] w_wb_src;
    logic       w_halted;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       w_illegal_set;
    logic       r_illegal;
`endif

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    always_comb begin
        w_bad_instr = 1'b0;
        case (opcode)
            c_OP_REG, c_OP_IMM, c_OP_LOAD, c_OP_STORE, c_OP_JAL,
            c_OP_JALR, c_OP_LUI, c_OP_AUIPC, c_OP_SYSTEM: w_bad_instr = 1'b0;
            // funct3 010/011 have no branch encoding
            c_OP_BRANCH: w_bad_instr = (funct3[2:1] == 2'b01);
            default:     w_bad_instr = 1'b1;
        endcase
    end

    // funct7_5 selects SUB/SRA for register ops; immediate ops only honour
    // it for the shift-right pair (ADDI has no subtract form).
    always_comb begin
        logic w_alt;
        w_alt = funct7_5 & ((r_state == S_EXEC_R) || (funct3 == 3'b101));
        case (funct3)
            3'b000:  w_exec_op = w_alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  w_exec_op = c_ALU_SLL;
            3'b010:  w_exec_op = c_ALU_SLT;
            3'b011:  w_exec_op = c_ALU_SLTU;
            3'b100:  w_exec_op = c_ALU_XOR;
            3'b101:  w_exec_op = w_alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  w_exec_op = c_ALU_OR;
            default: w_exec_op = c_ALU_AND;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  w_branch_taken = alu_zero;
            3'b001:  w_branch_taken = ~alu_zero;
            3'b100:  w_branch_taken = alu_lt;
            3'b101:  w_branch_taken = ~alu_lt;
            3'b110:  w_branch_taken = alu_ltu;
            3'b111:  w_branch_taken = ~alu_ltu;
            default: w_branch_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = c_PC_ALU;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_src = 1'b0;
        w_alu_src_a    = c_A_PC;
        w_alu_src_b    = c_B_RS2;
        w_alu_op       = c_ALU_ADD;
        w_rf_write     = 1'b0;
        w_wb_src       = c_WB_ALUOUT;
        w_halted       = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_illegal_set  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 is computed while the fetch is outstanding
                w_mem_req      = 1'b1;
                w_mem_addr_src = 1'b0;
                w_alu_src_a    = c_A_PC;
                w_alu_src_b    = c_B_FOUR;
                if (mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_pc_src     = c_PC_ALU;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/JAL target (old_pc + imm) lands in ALUOut
                w_alu_src_a = c_A_OLD_PC;
                w_alu_src_b = c_B_IMM;
                if (w_bad_instr) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    w_illegal_set = 1'b1;
                    w_state_next  = S_HALT;
`else
                    w_state_next  = S_FETCH;
`endif
                end else begin
                    case (opcode)
                        c_OP_REG:    w_state_next = S_EXEC_R;
                        c_OP_IMM:    w_state_next = S_EXEC_I;
                        c_OP_LOAD,
                        c_OP_STORE:  w_state_next = S_ADDR;
                        c_OP_BRANCH: w_state_next = S_BRANCH;
                        c_OP_JAL:    w_state_next = S_JAL;
                        c_OP_JALR:   w_state_next = S_JALR;
                        c_OP_LUI:    w_state_next = S_LUI;
                        c_OP_AUIPC:  w_state_next = S_AUIPC;
                        c_OP_SYSTEM: w_state_next = S_HALT;
                        default:     w_state_next = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R: begin
                w_alu_src_a  = c_A_RS1;
                w_alu_src_b  = c_B_RS2;
                w_alu_op     = w_exec_op;
                w_state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_alu_src_a  = c_A_RS1;
                w_alu_src_b  = c_B_IMM;
                w_alu_op     = w_exec_op;
                w_state_next = S_ALU_WB;
            end
            S_LUI: begin
                w_alu_src_a  = c_A_ZERO;
                w_alu_src_b  = c_B_IMM;
                w_alu_op     = c_ALU_PASSB;
                w_state_next = S_ALU_WB;
            end
            S_AUIPC: begin
                w_alu_src_a  = c_A_OLD_PC;
                w_alu_src_b  = c_B_IMM;
                w_state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_rf_write   = 1'b1;
                w_wb_src     = c_WB_ALUOUT;
                w_state_next = S_FETCH;
            end
            S_ADDR: begin
                w_alu_src_a  = c_A_RS1;
                w_alu_src_b  = c_B_IMM;
                w_state_next = (opcode == c_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req      = 1'b1;
                w_mem_addr_src = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_rf_write   = 1'b1;
                w_wb_src     = c_WB_MDR;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req      = 1'b1;
                w_mem_we       = 1'b1;
                w_mem_addr_src = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_alu_src_a  = c_A_RS1;
                w_alu_src_b  = c_B_RS2;
                w_alu_op     = c_ALU_SUB;
                if (w_branch_taken) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = c_PC_ALUOUT;
                end
                w_state_next = S_FETCH;
            end
            S_JAL: begin
                w_rf_write   = 1'b1;
                w_wb_src     = c_WB_PC;
                w_pc_write   = 1'b1;
                w_pc_src     = c_PC_ALUOUT;
                w_state_next = S_FETCH;
            end
            S_JALR: begin
                w_alu_src_a  = c_A_RS1;
                w_alu_src_b  = c_B_IMM;
                w_rf_write   = 1'b1;
                w_wb_src     = c_WB_PC;
                w_pc_write   = 1'b1;
                w_pc_src     = c_PC_ALU_EVEN;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_halted     = 1'b1;
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = c_RESET_STATE;
            end
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_illegal_set) begin
            r_illegal <= 1'b1;
        end
    end
    assign illegal = r_illegal & ~rst;
`else
    assign illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs are forced low while rst is high so a reset arriving
    // mid-transaction drops the memory request and every write enable in
    // the same cycle, even though the reset state itself is FETCH.
    // ------------------------------------------------------------------
    assign ir_write     = w_ir_write     & ~rst;
    assign pc_write     = w_pc_write     & ~rst;
    assign pc_src       = rst ? 2'd0 : w_pc_src;
    assign mem_req      = w_mem_req      & ~rst;
    assign mem_we       = w_mem_we       & ~rst;
    assign mem_addr_src = w_mem_addr_src & ~rst;
    assign alu_src_a    = rst ? 2'd0 : w_alu_src_a;
    assign alu_src_b    = rst ? 2'd0 : w_alu_src_b;
    assign alu_op       = rst ? 4'd0 : w_alu_op;
    assign rf_write     = w_rf_write     & ~rst;
    assign wb_src       = rst ? 2'd0 : w_wb_src;
    assign halted       = w_halted       & ~rst;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control. Each
//                task drives one instruction or scenario with a per-cycle
//                mem_ready pattern and compares the recorded controls against
//                hand-derived values.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_EXEC_I = 4'd4;
    localparam logic [3:0] ST_LUI    = 4'd5;
    localparam logic [3:0] ST_ALU_WB = 4'd7;
    localparam logic [3:0] ST_ADDR   = 4'd8;
    localparam logic [3:0] ST_MEM_RD = 4'd9;
    localparam logic [3:0] ST_MEM_WB = 4'd10;
    localparam logic [3:0] ST_MEM_WR = 4'd11;
    localparam logic [3:0] ST_BRANCH = 4'd12;
    localparam logic [3:0] ST_JAL    = 4'd13;
    localparam logic [3:0] ST_JALR   = 4'd14;
    localparam logic [3:0] ST_HALT   = 4'd15;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       alu_zero;
    logic       alu_lt;
    logic       alu_ltu;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       rf_write;
    logic [1:0] wb_src;
    logic       halted;
    logic       illegal;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .alu_ltu      (alu_ltu),
        .mem_ready    (mem_ready),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_src (mem_addr_src),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .rf_write     (rf_write),
        .wb_src       (wb_src),
        .halted       (halted),
        .illegal      (illegal),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       req;
        logic       we;
        logic       mas;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [3:0] op;
        logic       rfw;
        logic [1:0] wbs;
        logic       hlt;
        logic       ill;
    } obs_t;

    obs_t lg [16];

    // Drive one instruction for ncyc+1 cycles starting in FETCH (called at
    // posedge+1). rdy[i] is mem_ready in cycle i; bit ncyc should be 0 so
    // the machine parks in the following FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic z, input logic lt,
                             input logic ltu, input logic [15:0] rdy,
                             input int ncyc);
        for (int i = 0; i < 16; i++) lg[i] = '0;
        for (int i = 0; i <= ncyc && i < 16; i++) begin
            opcode    = op;
            funct3    = f3;
            funct7_5  = f75;
            alu_zero  = z;
            alu_lt    = lt;
            alu_ltu   = ltu;
            mem_ready = rdy[i];
            @(negedge clk);
            lg[i].st  = state;
            lg[i].irw = ir_write;
            lg[i].pcw = pc_write;
            lg[i].pcs = pc_src;
            lg[i].req = mem_req;
            lg[i].we  = mem_we;
            lg[i].mas = mem_addr_src;
            lg[i].asa = alu_src_a;
            lg[i].asb = alu_src_b;
            lg[i].op  = alu_op;
            lg[i].rfw = rf_write;
            lg[i].wbs = wb_src;
            lg[i].hlt = halted;
            lg[i].ill = illegal;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        funct3 = 3'b000;
        @(posedge clk);
        #1;
        n_cmp++; if (state !== ST_FETCH) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", state, ST_FETCH); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
        n_cmp++; if ({ir_write, pc_write, rf_write, mem_we} !== 4'b0000) begin n_bad++; $display("FAIL reset_write_en: got %b want 0000", {ir_write, pc_write, rf_write, mem_we}); end
        n_cmp++; if ({illegal, halted, alu_src_b} !== 4'b0000) begin n_bad++; $display("FAIL reset_misc: got %b want 0000", {illegal, halted, alu_src_b}); end
        mem_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if ({state, mem_req, alu_src_b, ir_write} !== {ST_FETCH, 1'b1, 2'd2, 1'b0}) begin n_bad++; $display("FAIL reset_release: got %b want %b", {state, mem_req, alu_src_b, ir_write}, {ST_FETCH, 1'b1, 2'd2, 1'b0}); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        logic [3:0] es [5];
        int nrf;
        es = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_ALU_WB, ST_FETCH};
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (lg[i].st !== es[i]) begin n_bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, lg[i].st, es[i]); end
        end
        n_cmp++; if ({lg[0].irw, lg[0].pcw, lg[0].pcs, lg[0].req, lg[0].mas, lg[0].asa, lg[0].asb} !== {1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd2}) begin n_bad++; $display("FAIL add_fetch_ctl: got %b", {lg[0].irw, lg[0].pcw, lg[0].pcs, lg[0].req, lg[0].mas, lg[0].asa, lg[0].asb}); end
        n_cmp++; if ({lg[1].asa, lg[1].asb} !== {2'd1, 2'd1}) begin n_bad++; $display("FAIL add_decode_src: got %b want 0101", {lg[1].asa, lg[1].asb}); end
        n_cmp++; if ({lg[2].op, lg[2].asa, lg[2].asb} !== {4'd0, 2'd2, 2'd0}) begin n_bad++; $display("FAIL add_exec: got %b want 00001000", {lg[2].op, lg[2].asa, lg[2].asb}); end
        nrf = 0;
        for (int i = 0; i < 4; i++) nrf += int'(lg[i].rfw);
        n_cmp++; if (nrf !== 1) begin n_bad++; $display("FAIL add_rf_pulses: got %0d want 1", nrf); end
        n_cmp++; if ({lg[3].rfw, lg[3].wbs} !== 3'b100) begin n_bad++; $display("FAIL add_wb: got %b want 100", {lg[3].rfw, lg[3].wbs}); end
    endtask

    task automatic test_alu_variants();
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        n_cmp++; if (lg[2].op !== 4'd1) begin n_bad++; $display("FAIL sub_alu_op: got %0d want 1", lg[2].op); end
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        n_cmp++; if ({lg[2].st, lg[2].op, lg[2].asb} !== {ST_EXEC_I, 4'd7, 2'd1}) begin n_bad++; $display("FAIL srai_exec: got %b want %b", {lg[2].st, lg[2].op, lg[2].asb}, {ST_EXEC_I, 4'd7, 2'd1}); end
        // ADDI with bit 30 set must still add
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        n_cmp++; if (lg[2].op !== 4'd0) begin n_bad++; $display("FAIL addi_f75_ignored: got %0d want 0", lg[2].op); end
        run_instr(7'b0110011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        n_cmp++; if (lg[2].op !== 4'd4) begin n_bad++; $display("FAIL sltu_alu_op: got %0d want 4", lg[2].op); end
        run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        n_cmp++; if (lg[2].op !== 4'd8) begin n_bad++; $display("FAIL ori_alu_op: got %0d want 8", lg[2].op); end
    endtask

    task automatic test_load_wait();
        logic [3:0] es [9];
        int nreq;
        es = '{ST_FETCH, ST_DECODE, ST_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_MEM_WB, ST_FETCH};
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0041, 8);
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if (lg[i].st !== es[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, lg[i].st, es[i]); end
        end
        nreq = 0;
        for (int i = 3; i < 7; i++) nreq += int'(lg[i].req & lg[i].mas & ~lg[i].we);
        n_cmp++; if (nreq !== 4) begin n_bad++; $display("FAIL lw_req_held: got %0d want 4", nreq); end
        n_cmp++; if ({lg[2].asa, lg[2].asb, lg[2].op} !== {2'd2, 2'd1, 4'd0}) begin n_bad++; $display("FAIL lw_addr: got %b want 10010000", {lg[2].asa, lg[2].asb, lg[2].op}); end
        n_cmp++; if ({lg[7].rfw, lg[7].wbs, lg[7].req} !== 4'b1010) begin n_bad++; $display("FAIL lw_wb: got %b want 1010", {lg[7].rfw, lg[7].wbs, lg[7].req}); end
    endtask

    task automatic test_store();
        int nrf;
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0009, 4);
        n_cmp++; if ({lg[2].st, lg[3].st, lg[4].st} !== {ST_ADDR, ST_MEM_WR, ST_FETCH}) begin n_bad++; $display("FAIL sw_states: got %b want %b", {lg[2].st, lg[3].st, lg[4].st}, {ST_ADDR, ST_MEM_WR, ST_FETCH}); end
        n_cmp++; if ({lg[3].req, lg[3].we, lg[3].mas} !== 3'b111) begin n_bad++; $display("FAIL sw_mem_ctl: got %b want 111", {lg[3].req, lg[3].we, lg[3].mas}); end
        nrf = 0;
        for (int i = 0; i < 4; i++) nrf += int'(lg[i].rfw);
        n_cmp++; if (nrf !== 0) begin n_bad++; $display("FAIL sw_no_rf_write: got %0d want 0", nrf); end
    endtask

    task automatic test_branch();
        // BNE, equal operands -> not taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 3);
        n_cmp++; if ({lg[2].st, lg[3].st} !== {ST_BRANCH, ST_FETCH}) begin n_bad++; $display("FAIL bne_nt_states: got %b want %b", {lg[2].st, lg[3].st}, {ST_BRANCH, ST_FETCH}); end
        n_cmp++; if ({lg[2].pcw, lg[2].op, lg[2].asa, lg[2].asb} !== {1'b0, 4'd1, 2'd2, 2'd0}) begin n_bad++; $display("FAIL bne_nt_ctl: got %b want 0000110 00", {lg[2].pcw, lg[2].op, lg[2].asa, lg[2].asb}); end
        // BNE, different operands -> taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 3);
        n_cmp++; if ({lg[2].pcw, lg[2].pcs, lg[3].st} !== {1'b1, 2'd1, ST_FETCH}) begin n_bad++; $display("FAIL bne_t: got %b want %b", {lg[2].pcw, lg[2].pcs, lg[3].st}, {1'b1, 2'd1, ST_FETCH}); end
        // BGE with lt=0 -> taken; BLTU with ltu=0 -> not taken
        run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 3);
        n_cmp++; if (lg[2].pcw !== 1'b1) begin n_bad++; $display("FAIL bge_taken: got %b want 1", lg[2].pcw); end
        run_instr(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 3);
        n_cmp++; if (lg[2].pcw !== 1'b0) begin n_bad++; $display("FAIL bltu_not_taken: got %b want 0", lg[2].pcw); end
    endtask

    task automatic test_jumps();
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 3);
        n_cmp++; if ({lg[2].st, lg[2].rfw, lg[2].wbs, lg[2].pcw, lg[2].pcs, lg[3].st} !== {ST_JAL, 1'b1, 2'd2, 1'b1, 2'd1, ST_FETCH}) begin n_bad++; $display("FAIL jal: got %b", {lg[2].st, lg[2].rfw, lg[2].wbs, lg[2].pcw, lg[2].pcs, lg[3].st}); end
        run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 3);
        n_cmp++; if ({lg[2].st, lg[2].asa, lg[2].asb, lg[2].op, lg[2].rfw, lg[2].wbs, lg[2].pcw, lg[2].pcs} !== {ST_JALR, 2'd2, 2'd1, 4'd0, 1'b1, 2'd2, 1'b1, 2'd2}) begin n_bad++; $display("FAIL jalr: got %b", {lg[2].st, lg[2].asa, lg[2].asb, lg[2].op, lg[2].rfw, lg[2].wbs, lg[2].pcw, lg[2].pcs}); end
        n_cmp++; if (lg[3].st !== ST_FETCH) begin n_bad++; $display("FAIL jalr_len: got %0d want %0d", lg[3].st, ST_FETCH); end
    endtask

    task automatic test_lui_fetch_wait();
        // Fetch waits two cycles, then LUI
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 6);
        n_cmp++; if ({lg[0].st, lg[0].req, lg[0].irw, lg[1].st, lg[1].req, lg[1].irw} !== {ST_FETCH, 2'b10, ST_FETCH, 2'b10}) begin n_bad++; $display("FAIL fetch_wait: got %b", {lg[0].st, lg[0].req, lg[0].irw, lg[1].st, lg[1].req, lg[1].irw}); end
        n_cmp++; if ({lg[2].irw, lg[2].pcw, lg[3].st} !== {2'b11, ST_DECODE}) begin n_bad++; $display("FAIL fetch_done: got %b", {lg[2].irw, lg[2].pcw, lg[3].st}); end
        n_cmp++; if ({lg[4].st, lg[4].asa, lg[4].asb, lg[4].op} !== {ST_LUI, 2'd3, 2'd1, 4'd10}) begin n_bad++; $display("FAIL lui_exec: got %b", {lg[4].st, lg[4].asa, lg[4].asb, lg[4].op}); end
        n_cmp++; if ({lg[5].st, lg[5].rfw, lg[6].st} !== {ST_ALU_WB, 1'b1, ST_FETCH}) begin n_bad++; $display("FAIL lui_wb: got %b", {lg[5].st, lg[5].rfw, lg[6].st}); end
    endtask

    task automatic test_halt();
        run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 4);
        n_cmp++; if ({lg[2].st, lg[2].hlt, lg[4].st, lg[4].hlt, lg[4].ill} !== {ST_HALT, 1'b1, ST_HALT, 1'b1, 1'b0}) begin n_bad++; $display("FAIL halt: got %b", {lg[2].st, lg[2].hlt, lg[4].st, lg[4].hlt, lg[4].ill}); end
        do_reset();
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 3);
        n_cmp++; if ({lg[1].ill, lg[2].st, lg[2].hlt, lg[2].ill, lg[3].st, lg[3].ill} !== {1'b0, ST_HALT, 2'b11, ST_HALT, 1'b1}) begin n_bad++; $display("FAIL illegal_trap: got %b", {lg[1].ill, lg[2].st, lg[2].hlt, lg[2].ill, lg[3].st, lg[3].ill}); end
        do_reset();
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_cleared: got %b want 0", illegal); end
        run_instr(7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 3);
        n_cmp++; if ({lg[2].st, lg[2].ill} !== {ST_HALT, 1'b1}) begin n_bad++; $display("FAIL bad_branch_trap: got %b", {lg[2].st, lg[2].ill}); end
        do_reset();
`else
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 2);
        n_cmp++; if ({lg[1].st, lg[2].st, lg[1].ill, lg[2].ill, lg[2].hlt} !== {ST_DECODE, ST_FETCH, 3'b000}) begin n_bad++; $display("FAIL illegal_nop: got %b", {lg[1].st, lg[2].st, lg[1].ill, lg[2].ill, lg[2].hlt}); end
        run_instr(7'b1100011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 2);
        n_cmp++; if ({lg[2].st, lg[1].pcw, lg[2].ill} !== {ST_FETCH, 2'b00}) begin n_bad++; $display("FAIL bad_branch_nop: got %b", {lg[2].st, lg[1].pcw, lg[2].ill}); end
`endif
    endtask

    task automatic test_reset_mid_memrd();
        opcode    = 7'b0000011;
        funct3    = 3'b010;
        funct7_5  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if ({state, mem_req, mem_addr_src} !== {ST_MEM_RD, 2'b11}) begin n_bad++; $display("FAIL mid_memrd_pre: got %b want %b", {state, mem_req, mem_addr_src}, {ST_MEM_RD, 2'b11}); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({state, mem_req, mem_addr_src, rf_write} !== {ST_FETCH, 3'b000}) begin n_bad++; $display("FAIL mid_memrd_rst: got %b want %b", {state, mem_req, mem_addr_src, rf_write}, {ST_FETCH, 3'b000}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if ({state, mem_req, mem_addr_src} !== {ST_FETCH, 2'b10}) begin n_bad++; $display("FAIL mid_memrd_release: got %b want %b", {state, mem_req, mem_addr_src}, {ST_FETCH, 2'b10}); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7_5  = 1'b0;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        alu_ltu   = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_alu_variants();
        test_load_wait();
        test_store();
        test_branch();
        test_jumps();
        test_lui_fetch_wait();
        test_halt();
        test_illegal();
        test_reset_mid_memrd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
